// File: rtl/count_7sd_multi.sv
// count_7sd_multi: multi-digit, multi-mode counter driving N active-low seven-segment digits
module count_7sd_multi #(
  parameter int NUM_DIGITS  = 2,
  parameter int RADIX_BCD   = 0,
  parameter int CLK_HZ      = 25000000,
  parameter int AUTO_HZ     = 1,
  parameter int HOLD_CYCLES = 50000000,
  parameter int BLANK_LZ    = 0
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  input  logic                    i_Mode_Next,
  input  logic                    i_Step,
  input  logic                    i_Dir,
  input  logic [3:0]              i_Bits,
  output logic [2:0]              o_Mode,
  output logic [4*NUM_DIGITS-1:0] o_Value,
  output logic                    o_Wrap,
  output logic [7*NUM_DIGITS-1:0] o_Segments
);
  localparam int DIV = CLK_HZ / AUTO_HZ;
  localparam int PW = $clog2(DIV);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [3:0] MAXD = (RADIX_BCD != 0) ? 4'd9 : 4'd15;
  localparam logic [2:0] IDLE = 3'd0, AUTO = 3'd1, STEP = 3'd2, BITS = 3'd3, CLEAR_WAIT = 3'd4;
  localparam logic [111:0] FONT = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                   7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  logic                    mode_cur, mode_prev, step_cur, step_prev;
  logic [3:0]              bits_cur, bits_prev, bits_rise, bit_d0;
  logic [PW-1:0]           presc;
  logic [HW-1:0]           hold;
  logic                    mode_fall, step_rise, hold_hit, tick, count_en, bit_ok, carry, seen;
  logic [4*NUM_DIGITS-1:0] cnt_val;
  logic [7*NUM_DIGITS-1:0] disp;
  logic [3:0]              d, s;
  assign mode_fall = mode_prev & ~mode_cur;
  assign step_rise = step_cur & ~step_prev;
  assign bits_rise = bits_cur & ~bits_prev;
  assign hold_hit  = mode_cur && hold == HW'(HOLD_CYCLES - 1);
  assign tick      = o_Mode == AUTO && presc == PW'(DIV - 1);
  assign count_en  = tick || (o_Mode == STEP && step_rise);
  assign bit_d0    = o_Value[3:0] ^ bits_rise;
  assign bit_ok    = |bits_rise && !(RADIX_BCD != 0 && bit_d0 > 4'd9);
  // Ripple one count through the digits in the direction given by i_Dir
  always_comb begin
    cnt_val = o_Value;
    carry = 1'b1;
    d = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = o_Value[4*i +: 4];
      cnt_val[4*i +: 4] = !carry ? d : i_Dir ? (d == 4'd0 ? MAXD : d - 4'd1) : (d == MAXD ? 4'd0 : d + 4'd1);
      carry = carry && (i_Dir ? d == 4'd0 : d == MAXD);
    end
  end
  // Display pattern per digit, with optional blanking of leading zeros
  always_comb begin
    disp = '1;
    seen = 1'b0;
    s = 4'd0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      s = o_Value[4*i +: 4];
      seen = seen || s != 4'd0;
      disp[7*i +: 7] = o_Mode == IDLE ? 7'h3F : o_Mode == CLEAR_WAIT ? 7'h2F :
                       (BLANK_LZ != 0 && i > 0 && !seen) ? 7'h7F : FONT[7*int'(s) +: 7];
    end
  end
  // Input edge detection, hold timing, prescaler, mode FSM and counter
  always_ff @(posedge i_Clk) begin
    mode_cur  <= i_Mode_Next;
    step_cur  <= i_Step;
    bits_cur  <= i_Bits;
    mode_prev <= i_Reset ? i_Mode_Next : mode_cur;
    step_prev <= i_Reset ? i_Step : step_cur;
    bits_prev <= i_Reset ? i_Bits : bits_cur;
    if (i_Reset) begin
      o_Mode     <= IDLE;
      o_Value    <= '0;
      o_Wrap     <= 1'b0;
      o_Segments <= '1;
      presc      <= '0;
      hold       <= '0;
    end else begin
      o_Segments <= disp;
      o_Wrap     <= 1'b0;
      hold       <= !mode_cur ? '0 : hold == HW'(HOLD_CYCLES) ? hold : hold + 1'b1;
      presc      <= (o_Mode == AUTO && !hold_hit && !mode_fall && !tick) ? presc + 1'b1 : '0;
      if (hold_hit) begin
        o_Value <= '0;
        o_Mode  <= CLEAR_WAIT;
      end else if (mode_fall) begin
        o_Mode <= (o_Mode == CLEAR_WAIT || o_Mode == BITS) ? IDLE : o_Mode + 3'd1;
      end else if (count_en) begin
        o_Value <= cnt_val;
        o_Wrap  <= carry;
      end else if (o_Mode == BITS && bit_ok) begin
        o_Value[3:0] <= bit_d0;
      end
    end
  end
endmodule

// File: tb/tb_count_7sd_multi.sv
// tb_count_7sd_multi: directed self-checking bench for hex, BCD and leading-zero-blanking counters
module tb_count_7sd_multi;
  localparam logic [6:0] S0 = 7'h40, S2 = 7'h24, S3 = 7'h30, S7 = 7'h78, SF = 7'h0E;
  localparam logic [6:0] DASH = 7'h3F, R = 7'h2F, BLK = 7'h7F;
  logic clk = 1'b0, rst = 1'b1, mode_next = 1'b0, step = 1'b1, dir = 1'b0;
  logic [3:0] bits = 4'd0;
  logic [2:0] mode_h, mode_b, mode_z;
  logic [7:0] val_h, val_b, val_z;
  logic wrap_h, wrap_b, wrap_z;
  logic [13:0] seg_h, seg_b, seg_z;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  count_7sd_multi #(.NUM_DIGITS(2), .RADIX_BCD(0), .CLK_HZ(100), .AUTO_HZ(10), .HOLD_CYCLES(20), .BLANK_LZ(0)) dut_h (
    .i_Clk(clk), .i_Reset(rst), .i_Mode_Next(mode_next), .i_Step(step), .i_Dir(dir), .i_Bits(bits),
    .o_Mode(mode_h), .o_Value(val_h), .o_Wrap(wrap_h), .o_Segments(seg_h));
  count_7sd_multi #(.NUM_DIGITS(2), .RADIX_BCD(1), .CLK_HZ(100), .AUTO_HZ(10), .HOLD_CYCLES(20), .BLANK_LZ(0)) dut_b (
    .i_Clk(clk), .i_Reset(rst), .i_Mode_Next(mode_next), .i_Step(step), .i_Dir(dir), .i_Bits(bits),
    .o_Mode(mode_b), .o_Value(val_b), .o_Wrap(wrap_b), .o_Segments(seg_b));
  count_7sd_multi #(.NUM_DIGITS(2), .RADIX_BCD(0), .CLK_HZ(100), .AUTO_HZ(10), .HOLD_CYCLES(20), .BLANK_LZ(1)) dut_z (
    .i_Clk(clk), .i_Reset(rst), .i_Mode_Next(mode_next), .i_Step(step), .i_Dir(dir), .i_Bits(bits),
    .o_Mode(mode_z), .o_Value(val_z), .o_Wrap(wrap_z), .o_Segments(seg_z));
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic press();
    mode_next = 1'b1;
    tick(2);
    mode_next = 1'b0;
    tick(2);
  endtask
  task automatic do_step();
    step = 1'b1;
    tick(2);
    step = 1'b0;
    tick(2);
  endtask
  initial begin
    tick(1);
    check("reset_seg", 32'(seg_h), 32'h3FFF);
    tick(2);
    rst = 1'b0;
    tick(3);
    check("rst_mode", 32'(mode_h), 0);
    check("rst_val_h", 32'(val_h), 0);
    check("rst_val_b", 32'(val_b), 0);
    check("rst_wrap", 32'(wrap_h), 0);
    check("rst_seg_idle", 32'(seg_h), 32'({DASH, DASH}));
    step = 1'b0;
    tick(2);
    check("held_step_val", 32'(val_h), 0);
    press();
    check("mode_auto", 32'(mode_h), 1);
    tick(9);
    check("auto_e9", 32'(val_h), 0);
    tick(1);
    check("auto_e10", 32'(val_h), 1);
    check("auto_e10_b", 32'(val_b), 1);
    step = 1'b1;
    tick(2);
    step = 1'b0;
    tick(7);
    check("auto_step_ign", 32'(val_h), 1);
    tick(1);
    check("auto_e20", 32'(val_h), 2);
    tick(1);
    check("seg_02", 32'(seg_h), 32'({S0, S2}));
    check("seg_lz_02", 32'(seg_z), 32'({BLK, S2}));
    tick(529);
    check("auto_37_h", 32'(val_h), 32'h37);
    check("auto_55_b", 32'(val_b), 32'h55);
    tick(1);
    check("seg_37", 32'(seg_h), 32'({S3, S7}));
    mode_next = 1'b1;
    tick(20);
    check("hold_p19_val", 32'(val_h), 32'h39);
    check("hold_p19_val_b", 32'(val_b), 32'h57);
    check("hold_p19_mode", 32'(mode_h), 1);
    tick(1);
    check("clear_val", 32'(val_h), 0);
    check("clear_mode", 32'(mode_h), 4);
    check("clear_wrap", 32'(wrap_h), 0);
    tick(4);
    check("cw_mode", 32'(mode_h), 4);
    check("cw_seg", 32'(seg_h), 32'({R, R}));
    mode_next = 1'b0;
    tick(2);
    check("cw_release", 32'(mode_h), 0);
    tick(1);
    check("cw_idle_seg", 32'(seg_h), 32'({DASH, DASH}));
    press();
    press();
    check("mode_step", 32'(mode_h), 2);
    dir = 1'b1;
    step = 1'b1;
    tick(2);
    check("down_val_h", 32'(val_h), 32'hFF);
    check("down_val_b", 32'(val_b), 32'h99);
    check("down_wrap_h", 32'(wrap_h), 1);
    check("down_wrap_b", 32'(wrap_b), 1);
    tick(1);
    check("down_wrap_end", 32'(wrap_h), 0);
    check("seg_ff", 32'(seg_h), 32'({SF, SF}));
    step = 1'b0;
    tick(2);
    dir = 1'b0;
    step = 1'b1;
    tick(2);
    check("up_wrap_val", 32'(val_h), 0);
    check("up_wrap_h", 32'(wrap_h), 1);
    step = 1'b0;
    tick(1);
    check("seg_lz_00", 32'(seg_z), 32'({BLK, S0}));
    tick(1);
    repeat (98) do_step();
    check("pre_98_b", 32'(val_b), 32'h98);
    check("pre_62_h", 32'(val_h), 32'h62);
    step = 1'b1;
    tick(2);
    check("bcd_99", 32'(val_b), 32'h99);
    check("bcd_99_wrap", 32'(wrap_b), 0);
    step = 1'b0;
    tick(2);
    step = 1'b1;
    tick(2);
    check("bcd_00", 32'(val_b), 0);
    check("bcd_00_wrap", 32'(wrap_b), 1);
    check("hex_64", 32'(val_h), 32'h64);
    check("hex_64_wrap", 32'(wrap_h), 0);
    tick(1);
    check("bcd_wrap_end", 32'(wrap_b), 0);
    step = 1'b0;
    tick(2);
    mode_next = 1'b1;
    tick(24);
    mode_next = 1'b0;
    tick(2);
    check("clr2_mode", 32'(mode_h), 0);
    check("clr2_val", 32'(val_h), 0);
    press();
    press();
    press();
    check("mode_bit", 32'(mode_h), 3);
    bits = 4'b0010;
    tick(2);
    check("bit_2_h", 32'(val_h), 2);
    check("bit_2_b", 32'(val_b), 2);
    bits = 4'b1010;
    tick(2);
    check("bit_a_h", 32'(val_h), 32'hA);
    check("bit_drop_b", 32'(val_b), 2);
    bits = 4'b0000;
    tick(2);
    check("bit_fall", 32'(val_h), 32'hA);
    bits = 4'b0101;
    tick(2);
    check("bit_mask_h", 32'(val_h), 32'hF);
    check("bit_mask_b", 32'(val_b), 7);
    do_step();
    check("bit_step_ign", 32'(val_h), 32'hF);
    press();
    check("bit_to_idle", 32'(mode_h), 0);
    bits = 4'b0000;
    tick(2);
    bits = 4'b1111;
    tick(2);
    check("idle_bits_ign", 32'(val_h), 32'hF);
    rst = 1'b1;
    tick(1);
    check("mid_rst_val", 32'(val_h), 0);
    check("mid_rst_mode", 32'(mode_h), 0);
    check("mid_rst_seg", 32'(seg_h), 32'h3FFF);
    rst = 1'b0;
    tick(3);
    check("post_rst_val", 32'(val_h), 0);
    check("post_rst_mode", 32'(mode_h), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
